// File: rtl/sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flex
// Description : Single-clock FIFO with arbitrary depth, an occupancy count,
//               programmable almost-full/almost-empty thresholds, selectable
//               standard or first-word-fall-through read mode, and one-cycle
//               overflow/underflow error pulses.
//
// Ports
//   clk          in   1      clock, all state changes on the rising edge
//   rst          in   1      asynchronous reset, active low
//   write        in   1      push request
//   read         in   1      pop request
//   data_in      in   WIDTH  push data
//   data_out     out  WIDTH  read data (registered, or head word in FWFT)
//   full         out  1      count == DEPTH
//   empty        out  1      count == 0
//   almost_full  out  1      count >= AFULL_THRESH
//   almost_empty out  1      count <= AEMPTY_THRESH
//   count        out  CW     occupancy 0..DEPTH, CW = $clog2(DEPTH+1)
//   overflow     out  1      pulse: a write was rejected last cycle
//   underflow    out  1      pulse: a read was rejected last cycle
//
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_flex #(
    parameter int DEPTH         = 8,
    parameter int WIDTH         = 8,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write,
    input  logic                       read,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AFULL    = c_CNT_W'(AFULL_THRESH);
    localparam logic [c_CNT_W-1:0] c_AEMPTY   = c_CNT_W'(AEMPTY_THRESH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic               w_rd_ok;
    logic               w_wr_ok;
    logic [c_PTR_W-1:0] w_wr_ptr_nxt;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;

    // Flags come straight from the count register so they never depend on
    // the current cycle's requests.
    assign w_full  = (r_count == c_CNT_FULL);
    assign w_empty = (r_count == '0);

    // A full FIFO still takes a write when a read frees a slot on the same
    // edge; an empty FIFO never satisfies a read, even with a concurrent write.
    assign w_rd_ok = read & ~w_empty;
    assign w_wr_ok = write & (~w_full | w_rd_ok);

    // Explicit wrap so a non-power-of-two depth has no hole at the end.
    assign w_wr_ptr_nxt = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
    assign w_rd_ptr_nxt = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_overflow  <= write & ~w_wr_ok;
            r_underflow <= read & ~w_rd_ok;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown combinationally; a word written this cycle
            // only appears after the edge that stores it.
            assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
        end else begin : g_std
            logic [WIDTH-1:0] r_dout;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_dout <= '0;
                end else if (w_rd_ok) begin
                    r_dout <= r_mem[r_rd_ptr];
                end
            end

            assign data_out = r_dout;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AFULL);
    assign almost_empty = (r_count <= c_AEMPTY);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_flex
// Description : Self-checking bench for sync_fifo_flex. Two instances share
//               clock and reset: u_std (DEPTH=5, standard read) and u_fwft
//               (DEPTH=4, first-word-fall-through). A queue-based reference
//               model per instance predicts every output after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_flex;

    localparam int c_D0  = 5;
    localparam int c_D1  = 4;
    localparam int c_AF0 = c_D0 - 1;
    localparam int c_AF1 = c_D1 - 1;
    localparam int c_AE  = 1;

    logic       clk;
    logic       rst;

    logic       r_wr0, r_rd0, r_wr1, r_rd1;
    logic [7:0] r_din0, r_din1;

    logic [7:0] w_dout0, w_dout1;
    logic       w_full0, w_empty0, w_af0, w_ae0, w_ovf0, w_unf0;
    logic       w_full1, w_empty1, w_af1, w_ae1, w_ovf1, w_unf1;
    logic [2:0] w_cnt0, w_cnt1;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] e_dout0;
    logic       e_ovf0, e_unf0, e_ovf1, e_unf1;

    sync_fifo_flex #(.DEPTH(c_D0), .WIDTH(8), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .write(r_wr0), .read(r_rd0), .data_in(r_din0),
        .data_out(w_dout0), .full(w_full0), .empty(w_empty0),
        .almost_full(w_af0), .almost_empty(w_ae0), .count(w_cnt0),
        .overflow(w_ovf0), .underflow(w_unf0)
    );

    sync_fifo_flex #(.DEPTH(c_D1), .WIDTH(8), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .write(r_wr1), .read(r_rd1), .data_in(r_din1),
        .data_out(w_dout1), .full(w_full1), .empty(w_empty1),
        .almost_full(w_af1), .almost_empty(w_ae1), .count(w_cnt1),
        .overflow(w_ovf1), .underflow(w_unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_all();
        int s0, s1;
        s0 = q0.size();
        s1 = q1.size();
        check("std.count",  32'(w_cnt0),   32'(s0));
        check("std.full",   32'(w_full0),  32'(s0 == c_D0));
        check("std.empty",  32'(w_empty0), 32'(s0 == 0));
        check("std.afull",  32'(w_af0),    32'(s0 >= c_AF0));
        check("std.aempty", 32'(w_ae0),    32'(s0 <= c_AE));
        check("std.dout",   32'(w_dout0),  32'(e_dout0));
        check("std.ovf",    32'(w_ovf0),   32'(e_ovf0));
        check("std.unf",    32'(w_unf0),   32'(e_unf0));
        check("fw.count",   32'(w_cnt1),   32'(s1));
        check("fw.full",    32'(w_full1),  32'(s1 == c_D1));
        check("fw.empty",   32'(w_empty1), 32'(s1 == 0));
        check("fw.afull",   32'(w_af1),    32'(s1 >= c_AF1));
        check("fw.aempty",  32'(w_ae1),    32'(s1 <= c_AE));
        check("fw.dout",    32'(w_dout1),  (s1 != 0) ? 32'(q1[0]) : 32'd0);
        check("fw.ovf",     32'(w_ovf1),   32'(e_ovf1));
        check("fw.unf",     32'(w_unf1),   32'(e_unf1));
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        e_dout0 = 8'h00;
        e_ovf0  = 1'b0;
        e_unf0  = 1'b0;
        e_ovf1  = 1'b0;
        e_unf1  = 1'b0;
    endtask

    // One clock cycle on both instances, followed by a full output check.
    task automatic cyc(input logic w0, input logic rd0, input logic [7:0] d0,
                       input logic w1, input logic rd1, input logic [7:0] d1);
        logic rok0, wok0, rok1, wok1;
        r_wr0 = w0; r_rd0 = rd0; r_din0 = d0;
        r_wr1 = w1; r_rd1 = rd1; r_din1 = d1;
        rok0 = rd0 && (q0.size() != 0);
        wok0 = w0 && ((q0.size() < c_D0) || rok0);
        rok1 = rd1 && (q1.size() != 0);
        wok1 = w1 && ((q1.size() < c_D1) || rok1);
        @(posedge clk);
        #1;
        if (rok0) e_dout0 = q0.pop_front();
        if (wok0) q0.push_back(d0);
        if (rok1) void'(q1.pop_front());
        if (wok1) q1.push_back(d1);
        e_ovf0 = w0 && !wok0;
        e_unf0 = rd0 && !rok0;
        e_ovf1 = w1 && !wok1;
        e_unf1 = rd1 && !rok1;
        check_all();
    endtask

    task automatic cyc0(input logic w0, input logic rd0, input logic [7:0] d0);
        cyc(w0, rd0, d0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic cyc1(input logic w1, input logic rd1, input logic [7:0] d1);
        cyc(1'b0, 1'b0, 8'h00, w1, rd1, d1);
    endtask

    initial begin
        int bias;
        rst = 1'b0;
        r_wr0 = 1'b0; r_rd0 = 1'b0; r_din0 = 8'h00;
        r_wr1 = 1'b0; r_rd1 = 1'b0; r_din1 = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all();

        // fill 0x01..0x05, then an overflowing 6th write
        for (int i = 1; i <= 5; i++) cyc0(1'b1, 1'b0, 8'(i));
        cyc0(1'b1, 1'b0, 8'h06);
        cyc0(1'b0, 1'b0, 8'h00);

        // drain in order, then an underflowing extra read
        for (int i = 0; i < 5; i++) cyc0(1'b0, 1'b1, 8'h00);
        cyc0(1'b0, 1'b1, 8'h00);
        cyc0(1'b0, 1'b0, 8'h00);

        // simultaneous read/write at full, then drain so 0xAA comes out last
        for (int i = 1; i <= 5; i++) cyc0(1'b1, 1'b0, 8'h40 + 8'(i));
        cyc0(1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < 5; i++) cyc0(1'b0, 1'b1, 8'h00);

        // simultaneous read/write at empty
        cyc0(1'b1, 1'b1, 8'h33);
        cyc0(1'b0, 1'b1, 8'h00);

        // FWFT: head visible without read, pop advances, zero when empty
        cyc1(1'b1, 1'b0, 8'h10);
        cyc1(1'b1, 1'b0, 8'h20);
        cyc1(1'b0, 1'b1, 8'h00);
        cyc1(1'b0, 1'b1, 8'h00);
        cyc1(1'b0, 1'b1, 8'h00);
        cyc1(1'b1, 1'b1, 8'h77);
        for (int i = 0; i < 5; i++) cyc1(1'b1, 1'b0, 8'h80 + 8'(i));
        cyc1(1'b1, 1'b1, 8'h99);
        for (int i = 0; i < 4; i++) cyc1(1'b0, 1'b1, 8'h00);

        // 12-word stream through DEPTH=5 with overlapping reads
        for (int i = 0; i < 12; i++) cyc0(1'b1, (i >= 2) && (i % 3 != 0), 8'hC0 + 8'(i));
        while (q0.size() != 0) cyc0(1'b0, 1'b1, 8'h00);

        // leave three words in each FIFO, then reset asynchronously mid-cycle
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'hD0 + 8'(i), 1'b1, 1'b0, 8'hE0 + 8'(i));
        check("pre_rst.count", 32'(w_cnt0), 32'd3);
        r_wr0 = 1'b0; r_rd0 = 1'b0; r_wr1 = 1'b0; r_rd1 = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 8'hA5);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00);

        // randomized traffic with shifting bias to reach both boundaries
        for (int i = 0; i < 600; i++) begin
            bias = ((i / 40) % 2 == 0) ? 75 : 25;
            cyc(($urandom_range(0, 99) < bias), ($urandom_range(0, 99) < 100 - bias), 8'($urandom),
                ($urandom_range(0, 99) < bias), ($urandom_range(0, 99) < 100 - bias), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
